// File: rtl/hilo_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_sequencer
//
// Multi-cycle HI/LO unit for a MIPS-style pipeline. It runs mult/multu as
// 32 radix-2 shift-add iterations and div/divu as 32 restoring iterations.
// mthi/mtlo complete in one cycle. Results are presented for exactly one
// cycle (DONE) with write pulses, and HI_result/LO_result then hold until
// the next DONE.
//
// Optional feature: define HILO_MULDIV_DIVIDE_EN to build the divider.
// Without it the DIV state and divider datapath are removed, and div/divu
// are reported through illegal_funct like any other unknown funct.
//
// Ports
//   clk                in   sole clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   start              in   decode issues a HI/LO op this cycle
//   funct[5:0]         in   op select (mult/multu/div/divu/mthi/mtlo)
//   operand_a[31:0]    in   rs value (multiplicand / dividend / mthi-mtlo data)
//   operand_b[31:0]    in   rt value (multiplier / divisor)
//   read_hi_lo         in   decode holds mfhi/mflo
//   busy               out  state != IDLE
//   stall              out  busy & (start | read_hi_lo), combinational
//   illegal_funct      out  one-cycle pulse for an unknown funct accepted in IDLE
//   HI_register_write  out  HI write pulse (DONE only)
//   LO_register_write  out  LO write pulse (DONE only)
//   HI_result[31:0]    out  HI value, valid from DONE until the next DONE
//   LO_result[31:0]    out  LO value, valid from DONE until the next DONE
// -----------------------------------------------------------------------------
module hilo_muldiv_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        read_hi_lo,
  output logic        busy,
  output logic        stall,
  output logic        illegal_funct,
  output logic        HI_register_write,
  output logic        LO_register_write,
  output logic [31:0] HI_result,
  output logic [31:0] LO_result
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef HILO_MULDIV_DIVIDE_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif
  localparam logic [5:0] LAST_ITER = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
`ifdef HILO_MULDIV_DIVIDE_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

`ifdef HILO_MULDIV_DIVIDE_EN
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction
`endif

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        wr_hi_q, wr_hi_d;
  logic        wr_lo_q, wr_lo_d;
  logic [31:0] hi_res_q, hi_res_d;
  logic [31:0] lo_res_q, lo_res_d;

  // Iteration datapath: acc holds the upper product half / partial remainder,
  // lo holds the lower product half (multiplier shifted out) / quotient.
  logic [5:0]  count_q, count_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opb_q, opb_d;
  logic        neg_q, neg_d;
`ifdef HILO_MULDIV_DIVIDE_EN
  logic        rneg_q, rneg_d;
  logic [33:0] dtrial;
`endif

  logic        op_signed;
  logic [32:0] madd;
  logic [63:0] prod_fix;

  // Signed variants (mult, div) have funct[0] clear.
  assign op_signed = ~funct[0];

  always_comb begin
    madd     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    prod_fix = neg_q ? neg64({acc_q, lo_q}) : {acc_q, lo_q};
`ifdef HILO_MULDIV_DIVIDE_EN
    // Shift the next dividend bit into the remainder, then trial-subtract.
    dtrial   = {1'b0, acc_q, lo_q[31]} - {2'b00, opb_q};
`endif

    state_d   = state_q;
    illegal_d = 1'b0;
    wr_hi_d   = wr_hi_q;
    wr_lo_d   = wr_lo_q;
    hi_res_d  = hi_res_q;
    lo_res_d  = lo_res_q;
    count_d   = count_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
`ifdef HILO_MULDIV_DIVIDE_EN
    rneg_d    = rneg_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          case (funct)
            F_MULT, F_MULTU: begin
              lo_d    = op_signed ? abs32(operand_a) : operand_a;
              opb_d   = op_signed ? abs32(operand_b) : operand_b;
              acc_d   = 32'd0;
              neg_d   = op_signed & (operand_a[31] ^ operand_b[31]);
              count_d = 6'd0;
              wr_hi_d = 1'b1;
              wr_lo_d = 1'b1;
              state_d = MULT;
            end
`ifdef HILO_MULDIV_DIVIDE_EN
            F_DIV, F_DIVU: begin
              wr_hi_d = 1'b1;
              wr_lo_d = 1'b1;
              if (operand_b == 32'd0) begin
                hi_res_d = operand_a;
                lo_res_d = 32'hFFFF_FFFF;
                state_d  = DONE;
              end else begin
                lo_d    = op_signed ? abs32(operand_a) : operand_a;
                opb_d   = op_signed ? abs32(operand_b) : operand_b;
                acc_d   = 32'd0;
                neg_d   = op_signed & (operand_a[31] ^ operand_b[31]);
                rneg_d  = op_signed & operand_a[31];
                count_d = 6'd0;
                state_d = DIV;
              end
            end
`endif
            F_MTHI: begin
              hi_res_d = operand_a;
              wr_hi_d  = 1'b1;
              wr_lo_d  = 1'b0;
              state_d  = DONE;
            end
            F_MTLO: begin
              lo_res_d = operand_a;
              wr_hi_d  = 1'b0;
              wr_lo_d  = 1'b1;
              state_d  = DONE;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end

      MULT: begin
        if (count_q == LAST_ITER) begin
          {hi_res_d, lo_res_d} = prod_fix;
          state_d              = DONE;
        end else begin
          // {carry, sum, lo} >> 1: the product register shifts right as the
          // consumed multiplier bit falls off the bottom.
          acc_d   = madd[32:1];
          lo_d    = {madd[0], lo_q[31:1]};
          count_d = count_q + 6'd1;
        end
      end

`ifdef HILO_MULDIV_DIVIDE_EN
      DIV: begin
        if (count_q == LAST_ITER) begin
          lo_res_d = neg_q  ? neg32(lo_q)  : lo_q;
          hi_res_d = rneg_q ? neg32(acc_q) : acc_q;
          state_d  = DONE;
        end else begin
          if (!dtrial[33]) begin
            acc_d = dtrial[31:0];
            lo_d  = {lo_q[30:0], 1'b1};
          end else begin
            acc_d = {acc_q[30:0], lo_q[31]};
            lo_d  = {lo_q[30:0], 1'b0};
          end
          count_d = count_q + 6'd1;
        end
      end
`endif

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
      wr_hi_q   <= 1'b0;
      wr_lo_q   <= 1'b0;
      hi_res_q  <= 32'd0;
      lo_res_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      wr_hi_q   <= wr_hi_d;
      wr_lo_q   <= wr_lo_d;
      hi_res_q  <= hi_res_d;
      lo_res_q  <= lo_res_d;
    end
  end

  // Iteration registers are only meaningful while MULT/DIV is active and are
  // always reloaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    acc_q   <= acc_d;
    lo_q    <= lo_d;
    opb_q   <= opb_d;
    neg_q   <= neg_d;
`ifdef HILO_MULDIV_DIVIDE_EN
    rneg_q  <= rneg_d;
`endif
  end

  assign busy              = (state_q != IDLE);
  assign stall             = busy & (start | read_hi_lo);
  assign illegal_funct     = illegal_q;
  assign HI_register_write = (state_q == DONE) & wr_hi_q;
  assign LO_register_write = (state_q == DONE) & wr_lo_q;
  assign HI_result         = hi_res_q;
  assign LO_result         = lo_res_q;

endmodule
